// File: rtl/stream_checker_pkg.sv
// Shared types and sizing helpers for the stream_checker in-order scoreboard.
package stream_checker_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISMATCH,
    ERR_UNDERFLOW,
    ERR_OVERFLOW
  } errKind_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_checker_if.sv
// Monitored push/pop handshakes of the DUT feeding the stream_checker.
interface stream_checker_if #(
  parameter int unsigned WIDTH = 8
);

  logic             i_pushed;
  logic [WIDTH-1:0] i_pushData;
  logic             i_popped;
  logic [WIDTH-1:0] i_popData;

  modport master (
    output i_pushed,
    output i_pushData,
    output i_popped,
    output i_popData
  );

  modport slave (
    input i_pushed,
    input i_pushData,
    input i_popped,
    input i_popData
  );

endinterface

// File: rtl/stream_checker_queue.sv
// Expected-data queue: flop array with wrapping pointers and a separate occupancy counter.
module stream_checker_queue
  import stream_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_clear,
  input  logic                          i_wr,
  input  logic                          i_rd,
  input  logic [WIDTH-1:0]              i_wrData,
  output logic [WIDTH-1:0]              o_head,
  output logic [occ_width(DEPTH)-1:0]   o_nEntries,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = occ_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (i_clear) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (i_wr) begin
        mem_d[wptr_q] = i_wrData;
        wptr_d        = ptr_next(wptr_q);
      end
      if (i_rd) begin
        rptr_d = ptr_next(rptr_q);
      end
      case ({i_wr, i_rd})
        2'b10:   cnt_d = cnt_q + OCC_W'(1);
        2'b01:   cnt_d = cnt_q - OCC_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    full_d  = (cnt_d == OCC_FULL);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_head     = mem_q[rptr_q];
  assign o_nEntries = cnt_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;

endmodule

// File: rtl/stream_checker.sv
// In-order scoreboard for a valid/ready stream: compares popped words against pushed ones.
// Define STREAM_CHECKER_COUNTERS_EN to add saturating o_nPushed/o_nPopped event counters.
module stream_checker
  import stream_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_cg,
  input  logic                         i_clear,
  stream_checker_if.slave              mon,
  output logic [occ_width(DEPTH)-1:0]  o_nEntries,
  output logic                         o_empty,
  output logic                         o_errPulse,
  output logic                         o_mismatch,
  output logic                         o_underflow,
  output logic                         o_overflow,
  output logic [WIDTH-1:0]             o_errExpected,
  output logic [WIDTH-1:0]             o_errActual
`ifdef STREAM_CHECKER_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]             o_nPushed,
  output logic [CNT_W-1:0]             o_nPopped
`endif
);

  logic             push_ev, pop_ev, q_clear;
  logic             push_acc, pop_acc;
  logic             q_full, q_empty;
  logic [WIDTH-1:0] q_head;
  errKind_t         err_kind;

  logic             err_pulse_q, err_pulse_d;
  logic             mismatch_q, mismatch_d;
  logic             underflow_q, underflow_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] err_exp_q, err_exp_d;
  logic [WIDTH-1:0] err_act_q, err_act_d;

  assign q_clear = i_cg & i_clear;
  assign push_ev = i_cg & ~i_clear & mon.i_pushed;
  assign pop_ev  = i_cg & ~i_clear & mon.i_popped;

  // Pop sees pre-cycle state; a pop on a full queue frees the slot the push reuses.
  assign pop_acc  = pop_ev & ~q_empty;
  assign push_acc = push_ev & (~q_full | pop_ev);

  stream_checker_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clear    (q_clear),
    .i_wr       (push_acc),
    .i_rd       (pop_acc),
    .i_wrData   (mon.i_pushData),
    .o_head     (q_head),
    .o_nEntries (o_nEntries),
    .o_full     (q_full),
    .o_empty    (q_empty)
  );

  // Underflow needs empty, overflow needs full and no pop: at most one kind per cycle.
  always_comb begin
    err_kind = ERR_NONE;
    if (pop_ev && q_empty) begin
      err_kind = ERR_UNDERFLOW;
    end else if (pop_acc && (q_head != mon.i_popData)) begin
      err_kind = ERR_MISMATCH;
    end else if (push_ev && q_full && !pop_ev) begin
      err_kind = ERR_OVERFLOW;
    end
  end

  always_comb begin
    err_pulse_d = err_pulse_q;
    mismatch_d  = mismatch_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    err_exp_d   = err_exp_q;
    err_act_d   = err_act_q;
    if (q_clear) begin
      err_pulse_d = 1'b0;
      mismatch_d  = 1'b0;
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
      err_exp_d   = '0;
      err_act_d   = '0;
    end else if (i_cg) begin
      err_pulse_d = (err_kind != ERR_NONE);
      case (err_kind)
        ERR_MISMATCH: begin
          mismatch_d = 1'b1;
          if (!mismatch_q) begin
            err_exp_d = q_head;
            err_act_d = mon.i_popData;
          end
        end
        ERR_UNDERFLOW: underflow_d = 1'b1;
        ERR_OVERFLOW:  overflow_d  = 1'b1;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      err_pulse_q <= 1'b0;
      mismatch_q  <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_exp_q   <= '0;
      err_act_q   <= '0;
    end else begin
      err_pulse_q <= err_pulse_d;
      mismatch_q  <= mismatch_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      err_exp_q   <= err_exp_d;
      err_act_q   <= err_act_d;
    end
  end

  assign o_empty       = q_empty;
  assign o_errPulse    = err_pulse_q;
  assign o_mismatch    = mismatch_q;
  assign o_underflow   = underflow_q;
  assign o_overflow    = overflow_q;
  assign o_errExpected = err_exp_q;
  assign o_errActual   = err_act_q;

`ifdef STREAM_CHECKER_COUNTERS_EN
  logic [CNT_W-1:0] n_pushed_q, n_pushed_d;
  logic [CNT_W-1:0] n_popped_q, n_popped_d;

  // Counts raw handshakes, so overflowed pushes and underflowed pops are included.
  always_comb begin
    n_pushed_d = n_pushed_q;
    n_popped_d = n_popped_q;
    if (q_clear) begin
      n_pushed_d = '0;
      n_popped_d = '0;
    end else begin
      if (push_ev && (n_pushed_q != '1)) n_pushed_d = n_pushed_q + CNT_W'(1);
      if (pop_ev && (n_popped_q != '1))  n_popped_d = n_popped_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      n_pushed_q <= '0;
      n_popped_q <= '0;
    end else begin
      n_pushed_q <= n_pushed_d;
      n_popped_q <= n_popped_d;
    end
  end

  assign o_nPushed = n_pushed_q;
  assign o_nPopped = n_popped_q;
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Scoreboard bench for stream_checker: a queue-based reference model predicts every cycle's outputs.
module tb_stream_checker;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rstn, cg, clear;
  always #5 clk = ~clk;

  stream_checker_if #(.WIDTH(WIDTH)) bus ();

  logic [OCC_W-1:0] o_nEntries;
  logic             o_empty, o_errPulse, o_mismatch, o_underflow, o_overflow;
  logic [WIDTH-1:0] o_errExpected, o_errActual;
`ifdef STREAM_CHECKER_COUNTERS_EN
  logic [31:0]      o_nPushed, o_nPopped;
`endif

  stream_checker #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_cg          (cg),
    .i_clear       (clear),
    .mon           (bus),
    .o_nEntries    (o_nEntries),
    .o_empty       (o_empty),
    .o_errPulse    (o_errPulse),
    .o_mismatch    (o_mismatch),
    .o_underflow   (o_underflow),
    .o_overflow    (o_overflow),
    .o_errExpected (o_errExpected),
    .o_errActual   (o_errActual)
`ifdef STREAM_CHECKER_COUNTERS_EN
    ,
    .o_nPushed     (o_nPushed),
    .o_nPopped     (o_nPopped)
`endif
  );

  typedef struct {
    int unsigned n;
    bit          empty, pulse, mism, under, over;
    int unsigned eexp, eact, npush, npop;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int unsigned mq[$];
  bit          m_pulse, m_mism, m_under, m_over;
  int unsigned m_eexp, m_eact, m_npush, m_npop;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask

  function automatic int unsigned head();
    return (mq.size() != 0) ? mq[0] : 0;
  endfunction

  task automatic model_zero();
    mq.delete();
    m_pulse = 0; m_mism = 0; m_under = 0; m_over = 0;
    m_eexp = 0; m_eact = 0; m_npush = 0; m_npop = 0;
  endtask

  task automatic drive(input bit rn, input bit cgv, input bit clr,
                       input bit push, input int unsigned pd,
                       input bit pop, input int unsigned popd);
    int unsigned pre;
    int unsigned h;
    exp_t e;
    @(negedge clk);
    rstn = rn; cg = cgv; clear = clr;
    bus.i_pushed = push; bus.i_pushData = pd[WIDTH-1:0];
    bus.i_popped = pop;  bus.i_popData  = popd[WIDTH-1:0];
    if (!rn) begin
      model_zero();
    end else if (cgv) begin
      if (clr) begin
        model_zero();
      end else begin
        pre = mq.size();
        m_pulse = 0;
        if (push && m_npush != 32'hFFFF_FFFF) m_npush++;
        if (pop && m_npop != 32'hFFFF_FFFF)   m_npop++;
        if (pop) begin
          if (pre == 0) begin
            m_under = 1; m_pulse = 1;
          end else begin
            h = mq.pop_front();
            if (h != (popd & 8'hFF)) begin
              if (!m_mism) begin m_eexp = h; m_eact = popd & 8'hFF; end
              m_mism = 1; m_pulse = 1;
            end
          end
        end
        if (push) begin
          if (pre == DEPTH && !pop) begin
            m_over = 1; m_pulse = 1;
          end else begin
            mq.push_back(pd & 8'hFF);
          end
        end
      end
    end
    e.n = mq.size(); e.empty = (mq.size() == 0); e.pulse = m_pulse;
    e.mism = m_mism; e.under = m_under; e.over = m_over;
    e.eexp = m_eexp; e.eact = m_eact; e.npush = m_npush; e.npop = m_npop;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic push_w(input int unsigned d);
    drive(1, 1, 0, 1, d, 0, 0);
  endtask

  task automatic pop_w(input int unsigned d);
    drive(1, 1, 0, 0, 0, 1, d);
  endtask

  task automatic do_clear();
    drive(1, 1, 1, 0, 0, 0, 0);
  endtask

  // Monitor: compares the DUT against the prediction made for the edge just taken.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("nEntries",    32'(o_nEntries),    e.n);
      chk("empty",       32'(o_empty),       32'(e.empty));
      chk("errPulse",    32'(o_errPulse),    32'(e.pulse));
      chk("mismatch",    32'(o_mismatch),    32'(e.mism));
      chk("underflow",   32'(o_underflow),   32'(e.under));
      chk("overflow",    32'(o_overflow),    32'(e.over));
      chk("errExpected", 32'(o_errExpected), e.eexp);
      chk("errActual",   32'(o_errActual),   e.eact);
`ifdef STREAM_CHECKER_COUNTERS_EN
      chk("nPushed",     o_nPushed,          e.npush);
      chk("nPopped",     o_nPopped,          e.npop);
`endif
    end
  end

  initial begin
    rstn = 1'b0; cg = 1'b0; clear = 1'b0;
    bus.i_pushed = 1'b0; bus.i_pushData = '0;
    bus.i_popped = 1'b0; bus.i_popData  = '0;
    model_zero();

    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 8'h99, 1, 0);
    idle();

    // In-order traffic with no errors
    push_w(8'h11); push_w(8'h22); push_w(8'h33);
    pop_w(8'h11); pop_w(8'h22); pop_w(8'h33);
    idle();

    // First mismatch is captured; later ones are not
    push_w(8'hA5); pop_w(8'h5A); idle();
    push_w(8'h01); pop_w(8'h02); idle();

    // Underflow, including push+pop on empty
    do_clear();
    pop_w(8'h00);
    drive(1, 1, 0, 1, 8'h77, 1, 8'h77);
    idle();
    pop_w(8'h77);
    idle();

    // Overflow on the push beyond capacity; stored words intact
    do_clear();
    for (int unsigned i = 0; i <= DEPTH; i++) push_w(i);
    idle();
    for (int unsigned i = 0; i < DEPTH; i++) pop_w(i);
    idle();

    // Wrap with a full queue under simultaneous push+pop
    do_clear();
    for (int unsigned i = 0; i < DEPTH; i++) push_w(8'h40 + i);
    for (int unsigned i = 0; i < 10; i++) drive(1, 1, 0, 1, 8'h40 + DEPTH + i, 1, 8'h40 + i);
    idle();

    // Gated cycles hold everything, including clear and reset-free pulses
    push_w(8'hEE); pop_w(8'h00);
    drive(1, 0, 0, 1, 8'h12, 1, 8'h34);
    drive(1, 0, 1, 1, 8'h56, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 8'hFF);
    idle();

    // Clear mid-stream
    push_w(8'h5C);
    drive(1, 1, 1, 1, 8'h66, 1, 8'h00);
    idle();

    // Randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      bit c, cl, pu, po;
      int unsigned pd, pod;
      c   = ($urandom_range(0, 9) != 0);
      cl  = ($urandom_range(0, 49) == 0);
      pu  = $urandom_range(0, 1) == 1;
      po  = $urandom_range(0, 1) == 1;
      pd  = $urandom_range(0, 255);
      pod = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : head();
      drive(1, c, cl, pu, pd, po, pod);
    end

    // Asynchronous reset mid-operation takes effect before the next edge
    push_w(8'hC3); push_w(8'h3C); pop_w(8'h00);
    drive(0, 1, 0, 1, 8'h10, 0, 0);
    #1;
    chk("async_rst_nEntries", 32'(o_nEntries), 32'd0);
    chk("async_rst_mismatch", 32'(o_mismatch), 32'd0);
    idle();
    push_w(8'h21); pop_w(8'h21);
    idle(); idle();

    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
